pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage 32-bit processor, sitting beside the opcode decoder and driving the PC, IF/ID and ID/EX register enables.
- Stalls on load-use hazards.
- Freezes fetch while a conditional branch resolves its compare in EX, then redirects or releases.
- Squashes wrong-path fetches on jumps and taken branches.
- Holds the pipe while the multi-cycle multiplier completes.

## Interface
Parameters:
- REG_AW, 4: register address width.
- MUL_CYCLES, 4: multiplier latency in EX, legal 1..16. A value of 1 means no multiply stall.

Ports:
- clk  in  1  system clock. One clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode_id  in  5  opcode of the instruction in ID.
- ra_id, rb_id  in  REG_AW  source register addresses in ID.
- opcode_ex  in  5  opcode of the instruction in EX.
- rd_ex  in  REG_AW  destination register of the instruction in EX.
- flags_ex  in  2  ALU compare flags produced in EX.
- pc_write  out  1  PC load enable.
- pc_sel  out  2  next-PC source: 00 sequential, 01 jump target, 10 branch target.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  load NOP (10111) into IF/ID.
- idex_bubble  out  1  load NOP into ID/EX instead of the decoded instruction.
- idex_hold  out  1  hold ID/EX and EX contents.
- mul_busy  out  1  multiplier stall in progress.

## Operation
- FSM states: RUN, BRWAIT, MULWAIT. A 4-bit down-counter mul_cnt is used in MULWAIT.
- Default outputs in RUN with no event: pc_write=1, ifid_write=1, pc_sel=00, all others 0.
- Evaluation priority, highest first: rst, MULWAIT, BRWAIT, multiply entry, load-use, branch entry, jump.
- rst: next state RUN, mul_cnt=0. Outputs while rst is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pc_sel=00, idex_hold=0, mul_busy=0.
- Multiply entry (RUN): opcode_ex=10110 and MUL_CYCLES>1. Go to MULWAIT with mul_cnt=MUL_CYCLES-2.
  - Stall outputs in the entry cycle and every MULWAIT cycle: pc_write=0, ifid_write=0, idex_hold=1, mul_busy=1.
  - MULWAIT: when mul_cnt=0, return to RUN; otherwise decrement.
- Load-use (RUN): all of the following must hold:
  - opcode_ex ∈ {01010, 01011};
  - rd_ex equals ra_id or rd_ex equals rb_id;
  - opcode_id ≠ 10111.
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1 for one cycle. State stays RUN. The bubble clears the condition on the next cycle.
- Branch entry (RUN): opcode_id ∈ {10100 BNE, 10101 BEQ} and no load-use.
  - Outputs: pc_write=0, ifid_write=0. The branch advances to EX.
  - Next state BRWAIT.
- BRWAIT: the branch is in EX. Resolve it as follows:
  - BEQ is taken iff flags_ex=01.
  - BNE is taken iff flags_ex ∈ {00, 10}.
  - flags_ex=11 is not-taken for both.
  - Taken: pc_sel=10, pc_write=1, ifid_flush=1.
  - Not taken: pc_sel=00, pc_write=1, ifid_write=1.
  - Next state RUN.
- Jump (RUN): opcode_id=10011. Outputs pc_sel=01, pc_write=1, ifid_flush=1 in the same cycle. State stays RUN.
- Unknown opcodes are treated as non-events.

## Timing
- All outputs are combinational from the state and current inputs. State and counter are registered.
- Load-use penalty: exactly 1 cycle.
- Branch penalty: 1 cycle if not taken, 2 cycles if taken (freeze plus flush).
- Jump penalty: 1 flushed slot.
- Multiply stall: exactly MUL_CYCLES-1 cycles with idex_hold=1. mul_busy drops in the cycle after the last hold.
- If rst is asserted mid-BRWAIT or mid-MULWAIT, the FSM returns to RUN on the next edge. A pending branch is discarded with no redirect, and mul_cnt is cleared.
- A load-use condition present during MULWAIT or BRWAIT is ignored and re-evaluated once the FSM is back in RUN.

## Structure
- Shared package pipe_pkg holds:
  - opcode constants OP_LDR=01010, OP_LDI=01011, OP_JMP=10011, OP_BNE=10100, OP_BEQ=10101, OP_MUL=10110, OP_NOP=10111;
  - PC_SEQ/PC_JMP/PC_BR encodings;
  - FSM state enum.
- One sub-module, hazard_mul_counter: loadable 4-bit down-counter with a zero flag.

## Test plan
- Load-use: opcode_ex=01010, rd_ex=3, ra_id=3 -> exactly one cycle with idex_bubble=1, pc_write=0; then pc_write=1.
- BEQ taken: opcode_id=10101 -> freeze cycle; next cycle flags_ex=01 -> pc_sel=10, ifid_flush=1, then RUN.
- BNE with flags_ex=01, then repeat with flags_ex=11 -> both not taken: pc_sel=00, ifid_write=1, no flush.
- Multiply with MUL_CYCLES=4: opcode_ex=10110 -> idex_hold=1, mul_busy=1 for exactly 3 cycles. With MUL_CYCLES=1 -> no stall.
- Reset mid-MULWAIT (cycle 2 of 3), then released -> RUN and default outputs next cycle; no residual stall.
- Jump: opcode_id=10011 while opcode_ex=01010 with rd_ex≠ra_id and rd_ex≠rb_id -> pc_sel=01, ifid_flush=1, no bubble.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the 5-stage pipeline sequencing logic.
//   - 5-bit opcode constants recognised by the hazard controller
//   - next-PC source encodings driven on pc_sel
//   - FSM state type of pipeline_hazard_ctrl
//   - small opcode classification helpers
package pipe_pkg;

    localparam logic [4:0] OP_LDR = 5'b01010;
    localparam logic [4:0] OP_LDI = 5'b01011;
    localparam logic [4:0] OP_JMP = 5'b10011;
    localparam logic [4:0] OP_BNE = 5'b10100;
    localparam logic [4:0] OP_BEQ = 5'b10101;
    localparam logic [4:0] OP_MUL = 5'b10110;
    localparam logic [4:0] OP_NOP = 5'b10111;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_JMP = 2'b01;
    localparam logic [1:0] PC_BR  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_BRWAIT  = 2'b01,
        ST_MULWAIT = 2'b10
    } state_t;

    // Instructions whose result is only available after the memory stage.
    function automatic logic is_load(input logic [4:0] op);
        return (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return (op == OP_BNE) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_mul_counter.sv
// hazard_mul_counter: loadable 4-bit down-counter with a zero flag, used to
// time the multiplier stall.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset, clears the count
//   load      in   load load_val (has priority over dec)
//   load_val  in   value to load
//   dec       in   decrement by one; saturates at zero
//   count     out  current count
//   zero      out  count == 0
module hazard_mul_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] count,
    output logic       zero
);

    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == 4'd0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequencing controller for the 5-stage pipeline.
// Produces PC / IF/ID / ID/EX control for load-use stalls, conditional branch
// freeze-and-resolve, jump squash and multi-cycle multiply holds.
// Parameters:
//   REG_AW      register address width
//   MUL_CYCLES  multiplier latency in EX (1..16); 1 means no multiply stall
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   opcode_id, ra_id, rb_id  instruction in ID
//   opcode_ex, rd_ex         instruction in EX
//   flags_ex                 ALU compare flags from EX
//   pc_write, pc_sel         PC load enable and next-PC source
//   ifid_write, ifid_flush   IF/ID load enable, load NOP into IF/ID
//   idex_bubble, idex_hold   load NOP into ID/EX, hold ID/EX and EX
//   mul_busy                 multiplier stall in progress
// All outputs are combinational from state and current inputs.
module pipeline_hazard_ctrl #(
    parameter int REG_AW     = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        opcode_id,
    input  logic [REG_AW-1:0] ra_id,
    input  logic [REG_AW-1:0] rb_id,
    input  logic [4:0]        opcode_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic [1:0]        flags_ex,
    output logic              pc_write,
    output logic [1:0]        pc_sel,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              idex_hold,
    output logic              mul_busy
);

    import pipe_pkg::*;

    localparam bit         MUL_STALLS = (MUL_CYCLES > 1);
    localparam logic [3:0] MUL_LOAD   = MUL_STALLS ? 4'(MUL_CYCLES - 2) : 4'd0;

    state_t state_reg, state_next;
    logic   br_beq_reg, br_beq_next;    // branch waiting in EX is a BEQ (else BNE)
    logic   cnt_load, cnt_dec, cnt_zero;
    logic [3:0] cnt_value;

    logic mul_entry, load_use, br_taken;

    hazard_mul_counter u_mul_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (MUL_LOAD),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .zero     (cnt_zero)
    );

    assign mul_entry = MUL_STALLS && (opcode_ex == OP_MUL);
    assign load_use  = is_load(opcode_ex)
                     && ((rd_ex == ra_id) || (rd_ex == rb_id))
                     && (opcode_id != OP_NOP);
    // flags_ex = 11 is not-taken for both branch kinds.
    assign br_taken  = br_beq_reg ? (flags_ex == 2'b01)
                                  : ((flags_ex == 2'b00) || (flags_ex == 2'b10));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_RUN;
            br_beq_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            br_beq_reg <= br_beq_next;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        pc_sel      = PC_SEQ;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        mul_busy    = 1'b0;
        state_next  = state_reg;
        br_beq_next = br_beq_reg;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_next  = ST_RUN;
        end else begin
            case (state_reg)
                ST_MULWAIT: begin
                    // The entry cycle is the first hold, so a zero count marks
                    // the multiply's last EX cycle: release the pipe and return.
                    // This keeps the hold at MUL_CYCLES-1 cycles and stops the
                    // still-resident MUL in EX from re-triggering an entry.
                    if (cnt_zero) begin
                        state_next = ST_RUN;
                    end else begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_hold  = 1'b1;
                        mul_busy   = 1'b1;
                        cnt_dec    = 1'b1;
                    end
                end
                ST_BRWAIT: begin
                    pc_write   = 1'b1;
                    state_next = ST_RUN;
                    if (br_taken) begin
                        pc_sel     = PC_BR;
                        ifid_write = 1'b0;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_sel     = PC_SEQ;
                        ifid_write = 1'b1;
                    end
                end
                default: begin
                    if (mul_entry) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_hold  = 1'b1;
                        mul_busy   = 1'b1;
                        cnt_load   = 1'b1;
                        state_next = ST_MULWAIT;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (is_branch(opcode_id)) begin
                        // Freeze fetch; the branch itself moves on to EX.
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        br_beq_next = (opcode_id == OP_BEQ);
                        state_next  = ST_BRWAIT;
                    end else if (opcode_id == OP_JMP) begin
                        pc_sel     = PC_JMP;
                        pc_write   = 1'b1;
                        ifid_write = 1'b0;
                        ifid_flush = 1'b1;
                    end
                    if (state_reg != ST_RUN) begin
                        state_next = ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: table-driven per-cycle vectors on a
// MUL_CYCLES=4 instance, plus hand-written sequences for the MUL_CYCLES=1
// instance and a bounded stall-length measurement.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 4;

    // Expected output encodings: {pc_write, pc_sel, ifid_write, ifid_flush,
    //                             idex_bubble, idex_hold, mul_busy}
    localparam logic [7:0] E_DEF = 8'b1_00_1_0_0_0_0;
    localparam logic [7:0] E_RST = 8'b0_00_0_1_1_0_0;
    localparam logic [7:0] E_LU  = 8'b0_00_0_0_1_0_0;
    localparam logic [7:0] E_FRZ = 8'b0_00_0_0_0_0_0;
    localparam logic [7:0] E_BRT = 8'b1_10_0_1_0_0_0;
    localparam logic [7:0] E_JMP = 8'b1_01_0_1_0_0_0;
    localparam logic [7:0] E_MUL = 8'b0_00_0_0_0_1_1;

    localparam logic [4:0] ALU = 5'b00000;
    localparam logic [4:0] LDR = 5'b01010;
    localparam logic [4:0] LDI = 5'b01011;
    localparam logic [4:0] JMP = 5'b10011;
    localparam logic [4:0] BNE = 5'b10100;
    localparam logic [4:0] BEQ = 5'b10101;
    localparam logic [4:0] MUL = 5'b10110;
    localparam logic [4:0] NOP = 5'b10111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    opcode_id, opcode_ex;
    logic [AW-1:0] ra_id, rb_id, rd_ex;
    logic [1:0]    flags_ex;

    logic       pc_write_a, ifid_write_a, ifid_flush_a, idex_bubble_a, idex_hold_a, mul_busy_a;
    logic [1:0] pc_sel_a;
    logic       pc_write_b, ifid_write_b, ifid_flush_b, idex_bubble_b, idex_hold_b, mul_busy_b;
    logic [1:0] pc_sel_b;

    pipeline_hazard_ctrl #(.REG_AW(AW), .MUL_CYCLES(4)) dut (
        .clk (clk), .rst (rst),
        .opcode_id (opcode_id), .ra_id (ra_id), .rb_id (rb_id),
        .opcode_ex (opcode_ex), .rd_ex (rd_ex), .flags_ex (flags_ex),
        .pc_write (pc_write_a), .pc_sel (pc_sel_a), .ifid_write (ifid_write_a),
        .ifid_flush (ifid_flush_a), .idex_bubble (idex_bubble_a),
        .idex_hold (idex_hold_a), .mul_busy (mul_busy_a)
    );

    pipeline_hazard_ctrl #(.REG_AW(AW), .MUL_CYCLES(1)) dut1 (
        .clk (clk), .rst (rst),
        .opcode_id (opcode_id), .ra_id (ra_id), .rb_id (rb_id),
        .opcode_ex (opcode_ex), .rd_ex (rd_ex), .flags_ex (flags_ex),
        .pc_write (pc_write_b), .pc_sel (pc_sel_b), .ifid_write (ifid_write_b),
        .ifid_flush (ifid_flush_b), .idex_bubble (idex_bubble_b),
        .idex_hold (idex_hold_b), .mul_busy (mul_busy_b)
    );

    wire [7:0] out_a = {pc_write_a, pc_sel_a, ifid_write_a, ifid_flush_a,
                        idex_bubble_a, idex_hold_a, mul_busy_a};
    wire [7:0] out_b = {pc_write_b, pc_sel_b, ifid_write_b, ifid_flush_b,
                        idex_bubble_b, idex_hold_b, mul_busy_b};

    typedef struct {
        logic          rst;
        logic [4:0]    op_id;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [4:0]    op_ex;
        logic [AW-1:0] rd;
        logic [1:0]    flags;
        logic [7:0]    exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic r, input logic [4:0] oid, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [4:0] oex,
                       input logic [AW-1:0] d, input logic [1:0] f, input logic [7:0] e);
        vec_t v;
        v.rst = r; v.op_id = oid; v.ra = a; v.rb = b;
        v.op_ex = oex; v.rd = d; v.flags = f; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [4:0] oid, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [4:0] oex,
                         input logic [AW-1:0] d, input logic [1:0] f);
        rst = r; opcode_id = oid; ra_id = a; rb_id = b;
        opcode_ex = oex; rd_ex = d; flags_ex = f;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s #%0d: outputs %b, required %b", name, idx, act, exp);
        end else begin
            $display("ok   %s #%0d: outputs %b", name, idx, act);
        end
    endtask

    // One cycle: drive just after the rising edge, sample at the falling edge.
    task automatic step(input logic r, input logic [4:0] oid, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input logic [4:0] oex,
                        input logic [AW-1:0] d, input logic [1:0] f);
        @(posedge clk);
        #1;
        drive(r, oid, a, b, oex, d, f);
        @(negedge clk);
    endtask

    int holds;

    initial begin
        drive(1'b1, ALU, 4'd0, 4'd0, ALU, 4'd0, 2'b11);

        //   rst   op_id ra rb  op_ex rd  flags  expected
        add(1'b1, ALU, 0, 0, ALU, 0, 2'b11, E_RST);
        add(1'b1, ALU, 0, 0, ALU, 0, 2'b11, E_RST);
        add(1'b0, ALU, 0, 0, ALU, 0, 2'b11, E_DEF);
        add(1'b0, ALU, 3, 0, LDR, 3, 2'b11, E_LU);   // load-use on ra
        add(1'b0, ALU, 3, 0, NOP, 0, 2'b11, E_DEF);  // bubble cleared it
        add(1'b0, ALU, 1, 5, LDI, 5, 2'b11, E_LU);   // load-use on rb
        add(1'b0, NOP, 5, 5, LDR, 5, 2'b11, E_DEF);  // NOP in ID never stalls
        add(1'b0, ALU, 1, 2, LDR, 7, 2'b11, E_DEF);  // no register match
        add(1'b0, BEQ, 1, 2, ALU, 0, 2'b11, E_FRZ);  // BEQ freeze
        add(1'b0, ALU, 1, 2, BEQ, 0, 2'b01, E_BRT);  // BEQ taken
        add(1'b0, ALU, 1, 2, ALU, 0, 2'b11, E_DEF);
        add(1'b0, BNE, 1, 2, ALU, 0, 2'b11, E_FRZ);
        add(1'b0, ALU, 1, 2, BNE, 0, 2'b01, E_DEF);  // BNE not taken on 01
        add(1'b0, BNE, 1, 2, ALU, 0, 2'b11, E_FRZ);
        add(1'b0, ALU, 1, 2, BNE, 0, 2'b11, E_DEF);  // 11 not taken
        add(1'b0, BNE, 1, 2, ALU, 0, 2'b11, E_FRZ);
        add(1'b0, ALU, 1, 2, BNE, 0, 2'b00, E_BRT);  // BNE taken on 00
        add(1'b0, BEQ, 1, 2, ALU, 0, 2'b11, E_FRZ);
        add(1'b0, ALU, 1, 2, BEQ, 0, 2'b11, E_DEF);  // BEQ not taken on 11
        add(1'b0, BEQ, 1, 2, ALU, 0, 2'b11, E_FRZ);
        add(1'b0, ALU, 1, 2, BEQ, 0, 2'b10, E_DEF);  // BEQ not taken on 10
        add(1'b0, BNE, 1, 2, ALU, 0, 2'b11, E_FRZ);
        add(1'b0, ALU, 1, 2, BNE, 0, 2'b10, E_BRT);  // BNE taken on 10
        add(1'b0, BEQ, 4, 2, LDR, 4, 2'b11, E_LU);   // load-use beats branch
        add(1'b0, ALU, 4, 2, NOP, 0, 2'b11, E_DEF);  // stayed in RUN
        add(1'b0, JMP, 1, 2, LDR, 6, 2'b11, E_JMP);  // jump, no hazard
        add(1'b0, JMP, 6, 2, LDR, 6, 2'b11, E_LU);   // load-use beats jump
        add(1'b0, BEQ, 1, 2, ALU, 0, 2'b11, E_FRZ);
        add(1'b0, ALU, 3, 2, LDR, 3, 2'b01, E_BRT);  // load-use ignored in BRWAIT
        add(1'b0, ALU, 1, 2, MUL, 0, 2'b11, E_MUL);  // multiply entry
        add(1'b0, ALU, 1, 2, MUL, 0, 2'b11, E_MUL);
        add(1'b0, ALU, 1, 2, MUL, 0, 2'b11, E_MUL);
        add(1'b0, ALU, 1, 2, MUL, 0, 2'b11, E_DEF);  // released after 3 holds
        add(1'b0, ALU, 1, 2, ALU, 0, 2'b11, E_DEF);
        add(1'b0, JMP, 1, 2, MUL, 0, 2'b11, E_MUL);  // multiply beats jump
        add(1'b0, JMP, 3, 2, MUL, 3, 2'b11, E_MUL);  // events ignored in MULWAIT
        add(1'b0, BEQ, 1, 2, MUL, 0, 2'b11, E_MUL);
        add(1'b0, ALU, 1, 2, MUL, 0, 2'b11, E_DEF);
        add(1'b0, ALU, 1, 2, ALU, 0, 2'b11, E_DEF);
        add(1'b0, ALU, 1, 2, MUL, 0, 2'b11, E_MUL);  // entry
        add(1'b0, ALU, 1, 2, MUL, 0, 2'b11, E_MUL);  // hold 2 of 3
        add(1'b1, ALU, 1, 2, MUL, 0, 2'b11, E_RST);  // reset mid-MULWAIT
        add(1'b0, ALU, 1, 2, ALU, 0, 2'b11, E_DEF);  // no residual stall
        add(1'b0, ALU, 1, 2, ALU, 0, 2'b11, E_DEF);
        add(1'b0, BEQ, 1, 2, ALU, 0, 2'b11, E_FRZ);
        add(1'b1, ALU, 1, 2, BEQ, 0, 2'b01, E_RST);  // reset mid-BRWAIT
        add(1'b0, ALU, 1, 2, ALU, 0, 2'b01, E_DEF);  // branch discarded
        add(1'b0, ALU, 1, 2, ALU, 0, 2'b11, E_DEF);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].op_id, vecs[i].ra, vecs[i].rb,
                 vecs[i].op_ex, vecs[i].rd, vecs[i].flags);
            check("vec", i, out_a, vecs[i].exp);
        end

        // MUL_CYCLES=1 instance: multiply never stalls and does not mask a jump.
        step(1'b1, ALU, 0, 0, ALU, 0, 2'b11);
        check("mul1_rst", 0, out_b, E_RST);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, ALU, 1, 2, MUL, 0, 2'b11);
            check("mul1_nostall", c, out_b, E_DEF);
        end
        step(1'b0, JMP, 1, 2, MUL, 0, 2'b11);
        check("mul1_jump", 0, out_b, E_JMP);

        // Measure the MUL_CYCLES=4 hold length with a bounded wait.
        step(1'b1, ALU, 0, 0, ALU, 0, 2'b11);
        check("mul4_rst", 0, out_a, E_RST);
        step(1'b0, ALU, 1, 2, MUL, 0, 2'b11);
        holds = 0;
        for (int c = 0; c < 16; c++) begin
            if (idex_hold_a !== 1'b1) break;
            holds++;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        check("mul4_len", 0, 8'(holds), 8'd3);
        check("mul4_release", 0, out_a, E_DEF);
        step(1'b0, ALU, 1, 2, ALU, 0, 2'b11);
        check("mul4_after", 0, out_a, E_DEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
